sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 19 +
 rtl/sipo_deser.sv | 124 ++++++++++++
 tb/tb_sipo_deser.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out deserialiser.
//   collect_state_t : collect-side FSM (IDLE = no bits held, COLLECT = partial word)
//   hold_state_t    : holding-register FSM (EMPTY = out_valid low, HOLD = word waiting)
//   SIPO_DEFAULT_WIDTH : default word width
package sipo_pkg;

   localparam int SIPO_DEFAULT_WIDTH = 4;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } collect_state_t;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } hold_state_t;

endpackage

// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserialiser with a one-word holding register.
// Bits arrive LSB first on serial_in, qualified by shift. When WIDTH bits are
// collected the word is offered to the holding register; if that register is
// still occupied and not being consumed, the word is dropped and the sticky
// overrun flag is raised.
// Ports:
//   clk          : clock, all state on rising edge
//   reset        : synchronous active-high reset
//   shift        : serial-bit strobe
//   serial_in    : serial data, LSB first
//   clear        : abort partial word and clear overrun
//   parallel_out : assembled word (stable while out_valid=1)
//   out_valid    : holding register contains an unconsumed word
//   out_ready    : consumer accepts the word when out_valid=1
//   overrun      : sticky, a completed word was dropped
//   bit_count    : number of bits in the current partial word
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         shift,
   input  logic                         serial_in,
   input  logic                         clear,
   output logic [WIDTH-1:0]             parallel_out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         overrun,
   output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   collect_state_t cstate, cstate_nxt;
   hold_state_t    hstate, hstate_nxt;

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] data;
   logic [CW-1:0]    cnt;
   logic             ovr;
   logic             last;
   logic             complete;
   logic             accept;
   logic             load;
   logic             drop;

   // Next-state and handshake decode.
   always_comb begin
      word       = {serial_in, sr[WIDTH-1:1]};
      last       = (cnt == LAST);
      // clear suppresses the sampled bit, so it can never complete a word
      complete   = shift && !clear && (cstate == COLLECT) && last;
      accept     = (hstate == HOLD) && out_ready;
      load       = complete && ((hstate == EMPTY) || out_ready);
      drop       = complete && (hstate == HOLD) && !out_ready;

      cstate_nxt = cstate;
      if (clear) begin
         cstate_nxt = IDLE;
      end else if (shift) begin
         case (cstate)
            IDLE:    cstate_nxt = COLLECT;
            COLLECT: if (last) cstate_nxt = IDLE;
            default: cstate_nxt = IDLE;
         endcase
      end

      hstate_nxt = hstate;
      if (load) begin
         hstate_nxt = HOLD;
      end else if (accept) begin
         hstate_nxt = EMPTY;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cstate <= IDLE;
         hstate <= EMPTY;
      end else begin
         cstate <= cstate_nxt;
         hstate <= hstate_nxt;
      end
   end

   // Datapath: shift register, bit counter, holding register, overrun flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr   <= '0;
         cnt  <= '0;
         data <= '0;
         ovr  <= 1'b0;
      end else begin
         if (clear) begin
            sr  <= '0;
            cnt <= '0;
         end else if (shift) begin
            sr  <= word;
            cnt <= complete ? '0 : cnt + CW'(1);
         end

         if (load) begin
            data <= word;
         end

         if (clear) begin
            ovr <= 1'b0;
         end else if (drop) begin
            ovr <= 1'b1;
         end
      end
   end

   assign parallel_out = data;
   assign out_valid    = (hstate == HOLD);
   assign overrun      = ovr;
   assign bit_count    = cnt;

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             shift = 1'b0;
   logic             serial_in = 1'b0;
   logic             clear = 1'b0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic             overrun;
   logic [2:0]       bit_count;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [WIDTH-1:0] exp_q[$];

   sipo_deser #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .shift        (shift),
      .serial_in    (serial_in),
      .clear        (clear),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overrun      (overrun),
      .bit_count    (bit_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; state is read there too.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic b);
      shift     = 1'b1;
      serial_in = b;
      tick();
   endtask

   task automatic idle(input int unsigned n);
      shift = 1'b0;
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] t;
      t = w;
      for (int unsigned i = 0; i < WIDTH; i++) send_bit(t[i]);
   endtask

   // Scoreboard: an accept happens on the next rising edge whenever
   // out_valid and out_ready are both high mid-cycle.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_word", {28'd0, parallel_out}, 32'hFFFF_FFFF);
         end else begin
            check("sb_word", {28'd0, parallel_out}, {28'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] piso;

      // Reset
      reset = 1'b1;
      idle(5);
      reset = 1'b0;
      check("rst_pout", parallel_out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_ovr", overrun, 0);
      check("rst_cnt", bit_count, 0);

      // Basic word, consumer not ready
      out_ready = 1'b0;
      send_bit(1'b0);
      send_bit(1'b0);
      check("basic_cnt2", bit_count, 2);
      send_bit(1'b1);
      send_bit(1'b0);
      exp_q.push_back(4'b0100);
      check("basic_valid", out_valid, 1);
      check("basic_pout", parallel_out, 4'b0100);
      check("basic_cnt0", bit_count, 0);

      // Overrun: second word completes while holding register occupied
      send_word(4'b1011);
      check("ovr_pout_kept", parallel_out, 4'b0100);
      check("ovr_set", overrun, 1);
      idle(3);
      check("ovr_sticky", overrun, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_ovr", overrun, 0);
      check("clr_keeps_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("accept_empty", out_valid, 0);

      // Streaming with out_ready held high
      out_ready = 1'b1;
      exp_q.push_back(4'hA);
      exp_q.push_back(4'h5);
      send_word(4'hA);
      check("strm_validA", out_valid, 1);
      check("strm_A", parallel_out, 4'hA);
      send_bit(1'b1);
      check("strm_hold1", parallel_out, 4'hA);
      send_bit(1'b0);
      check("strm_hold2", parallel_out, 4'hA);
      send_bit(1'b1);
      check("strm_hold3", parallel_out, 4'hA);
      send_bit(1'b0);
      check("strm_5", parallel_out, 4'h5);
      check("strm_valid5", out_valid, 1);
      check("strm_ovr", overrun, 0);
      idle(1);
      check("strm_drained", out_valid, 0);

      // Completion and accept on the same edge
      out_ready = 1'b0;
      exp_q.push_back(4'h3);
      exp_q.push_back(4'hC);
      send_word(4'h3);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      check("simul_pout_old", parallel_out, 4'h3);
      out_ready = 1'b1;
      send_bit(1'b1);
      check("simul_valid", out_valid, 1);
      check("simul_pout_new", parallel_out, 4'hC);
      check("simul_ovr", overrun, 0);
      idle(1);
      out_ready = 1'b0;
      check("simul_drained", out_valid, 0);

      // Abort: clear beats shift on the same edge
      send_bit(1'b1);
      send_bit(1'b1);
      check("abort_cnt2", bit_count, 2);
      clear = 1'b1;
      send_bit(1'b1);
      clear = 1'b0;
      check("abort_cnt0", bit_count, 0);
      exp_q.push_back(4'b0001);
      send_word(4'b0001);
      check("abort_pout", parallel_out, 4'b0001);
      check("abort_valid", out_valid, 1);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;

      // Reset mid-word while a word is held
      send_word(4'h6);
      check("rmid_valid", out_valid, 1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      check("rmid_cnt3", bit_count, 3);
      reset     = 1'b1;
      clear     = 1'b1;
      out_ready = 1'b1;
      shift     = 1'b1;
      tick();
      reset     = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      shift     = 1'b0;
      check("rmid_pout", parallel_out, 0);
      check("rmid_valid0", out_valid, 0);
      check("rmid_ovr", overrun, 0);
      check("rmid_cnt", bit_count, 0);
      exp_q.push_back(4'hF);
      send_word(4'hF);
      check("rmid_F", parallel_out, 4'hF);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;

      // Loopback from a parallel-in/serial-out shifter, with a long pause mid-word
      piso = 4'b0100;
      exp_q.push_back(4'b0100);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i == 2) begin
            idle(10);
            check("loop_pause_cnt", bit_count, 2);
         end
         send_bit(piso[0]);
         piso = {1'b0, piso[WIDTH-1:1]};
      end
      check("loop_pout", parallel_out, 4'b0100);
      out_ready = 1'b1;
      idle(2);
      out_ready = 1'b0;
      check("loop_drained", out_valid, 0);

      check("sb_leftover", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
